// File: rtl/feature_writer.sv
// Write-back serializer: captures a parallel N_WORDS result bus on a valid_in rise
// and streams it word-by-word into the feature RAM at a per-layer base address.
module feature_writer #(
    parameter int          N_WORDS  = 288,
    parameter int          ADDR_W   = 11,
    parameter int          DATA_LEN = 16,
    parameter logic [3:0]  LAYER0   = 4'd1,
    parameter logic [3:0]  LAYER1   = 4'd2,
    parameter logic [3:0]  LAYER2   = 4'd3,
    parameter logic [3:0]  LAYER3   = 4'd4,
    parameter logic [3:0]  AFFINE   = 4'd5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   cs,
    input  logic                         valid_in,
    input  logic [N_WORDS*DATA_LEN-1:0]  d,
    output logic                         we,
    output logic [ADDR_W-1:0]            waddr,
    output logic [DATA_LEN-1:0]          wdata,
    output logic                         busy,
    output logic                         done
);
    localparam int CNT_W = $clog2(N_WORDS + 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [ADDR_W-1:0]                 base_q, base_d;
    logic [ADDR_W-1:0]                 waddr_q, waddr_d;
    logic [DATA_LEN-1:0]               wdata_q, wdata_d;
    logic                              we_q, we_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              vin_q;
    logic [3:0]                        cs_q;
    logic [N_WORDS-1:0][DATA_LEN-1:0]  buf_q;

    logic                              trig, legal, cap;
    logic [ADDR_W-1:0]                 sel_base;

    assign trig = valid_in & ~vin_q;

    always_comb begin
        legal    = 1'b1;
        sel_base = '0;
        case (cs)
            LAYER0:  sel_base = '0;
            LAYER1:  sel_base = ADDR_W'(N_WORDS);
            LAYER2:  sel_base = ADDR_W'(2 * N_WORDS);
            LAYER3:  sel_base = ADDR_W'(3 * N_WORDS);
            AFFINE:  sel_base = ADDR_W'(4 * N_WORDS);
            default: legal    = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (trig && legal) begin
                    cap     = 1'b1;
                    base_d  = sel_base;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A layer change mid-transfer means the data no longer belongs here.
                if (cs != cs_q) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q < CNT_W'(N_WORDS)) begin
                    we_d    = 1'b1;
                    waddr_d = base_q + ADDR_W'(cnt_q);
                    wdata_d = buf_q[cnt_q];
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vin_q   <= 1'b0;
            cs_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vin_q   <= valid_in;
            cs_q    <= cs;
        end
    end

    // Capture buffer carries no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (cap) buf_q <= d;
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_feature_writer.sv
// Directed bench for feature_writer: transfers, layer bases, input stability, abort,
// illegal layer code, dropped retrigger and asynchronous reset mid-transfer.
module tb_feature_writer;
    localparam int NW = 288;
    localparam int DL = 16;
    localparam int AW = 11;
    localparam logic [3:0] L0 = 4'd1, L1 = 4'd2, L2 = 4'd3, L3 = 4'd4, AF = 4'd5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         cs = 4'd0;
    logic               valid_in = 1'b0;
    logic [NW*DL-1:0]   d = '0;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [DL-1:0]      wdata;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    feature_writer dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .valid_in(valid_in), .d(d),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_d(input int dbase);
        for (int i = 0; i < NW; i++) d[i*DL +: DL] = DL'(dbase + i);
    endtask

    // mode: 0 plain, 1 scramble d after capture, 2 hold valid_in high ~600 cycles,
    // 3 second valid_in rise around write 50
    task automatic xfer(input logic [3:0] c, input int wbase, input int dbase,
                        input int mode, input string tag);
        int bad;
        int extra_we;
        int extra_done;
        cs = c;
        load_d(dbase);
        valid_in = 1'b1;
        tick();
        if (mode != 2) valid_in = 1'b0;
        if (mode == 1) d = '1;
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_we_at_T"}, we, 0);
        bad = 0;
        for (int i = 0; i < NW; i++) begin
            if (mode == 3 && i == 48) valid_in = 1'b1;
            if (mode == 3 && i == 51) valid_in = 1'b0;
            tick();
            if (!(we === 1'b1 && waddr === AW'(wbase + i) && wdata === DL'(dbase + i)
                  && busy === 1'b1 && done === 1'b0)) bad++;
            if (i == 0) begin
                chk({tag, "_first_addr"}, waddr, wbase);
                chk({tag, "_first_data"}, wdata, DL'(dbase));
            end
        end
        chk({tag, "_bad_writes"}, bad, 0);
        chk({tag, "_last_addr"}, waddr, wbase + NW - 1);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_we_end"}, we, 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_waddr_hold"}, waddr, wbase + NW - 1);
        tick();
        chk({tag, "_done_fall"}, done, 0);
        extra_we = 0;
        extra_done = 0;
        for (int i = 0; i < ((mode == 2) ? 320 : 20); i++) begin
            tick();
            if (we === 1'b1) extra_we++;
            if (done === 1'b1) extra_done++;
        end
        valid_in = 1'b0;
        chk({tag, "_extra_we"}, extra_we, 0);
        chk({tag, "_extra_done"}, extra_done, 0);
        tick();
    endtask

    task automatic quiet(input int n, input string tag);
        int cnt_we;
        int cnt_done;
        int cnt_busy;
        cnt_we = 0;
        cnt_done = 0;
        cnt_busy = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (we === 1'b1) cnt_we++;
            if (done === 1'b1) cnt_done++;
            if (busy === 1'b1) cnt_busy++;
        end
        chk({tag, "_no_we"}, cnt_we, 0);
        chk({tag, "_no_done"}, cnt_done, 0);
        chk({tag, "_no_busy"}, cnt_busy, 0);
    endtask

    initial begin
        #2;
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        xfer(L0, 0, 0, 0, "basic");
        xfer(L2, 576, 1000, 0, "layer2");
        xfer(AF, 1152, 2000, 0, "affine");
        xfer(L1, 288, 3000, 1, "stable_d");
        xfer(L3, 864, 4000, 2, "hold_valid");
        xfer(L0, 0, 500, 3, "retrig");

        // Abort: layer code changes after 100 writes
        cs = L1;
        load_d(5000);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("abort_w100_addr", waddr, 288 + 99);
        chk("abort_w100_we", we, 1);
        cs = L3;
        tick();
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        quiet(300, "abort");
        xfer(L3, 864, 6000, 0, "after_abort");

        // Illegal layer code
        cs = 4'hF;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        quiet(300, "illegal");

        // Asynchronous reset mid-transfer
        cs = L0;
        load_d(7000);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        chk("pre_rst_we", we, 1);
        chk("pre_rst_addr", waddr, 199);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_waddr", waddr, 0);
        chk("mid_rst_wdata", wdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        xfer(L0, 0, 8000, 0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/feature_writer.md
# feature_writer

Write-back serializer between the compute array and the feature RAM. When a producer asserts `valid_in` with a full 288-word parallel result bus, the block captures the bus and writes each word, one per cycle, into a 2048-deep RAM. The write addresses are consecutive, starting at a per-layer base address selected by `cs`. It is the write-side counterpart of the weight loader, which deserializes a ROM stream into a parallel bus. This block does the reverse: it turns a parallel bus into a RAM write stream.

## Interface
- `N_WORDS`, default 288: words per transfer; also the per-layer address stride.
- `ADDR_W`, default 11: write-address width. The largest address is 5*288-1 = 1439.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cs`  in  4  layer state code (`LAYER0`..`LAYER3`, `AFFINE` from state_layer_data.v).
- `valid_in`  in  1  level valid from the producer; a 0→1 transition triggers a transfer.
- `d`  in  N_WORDS*`data_len`  parallel result bus; word i is `d[i*data_len +: data_len]`.
- `we`  out  1  RAM write enable.
- `waddr`  out  ADDR_W  RAM write address.
- `wdata`  out  `data_len`  RAM write data.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.

## Operation
- Clock is `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset state:
  - `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0.
  - FSM=IDLE, counter=0, `valid_in` history register=0, `cs` history register=0.
- FSM states: IDLE, WRITE.
- Trigger condition: `valid_in`=1 at the current edge, and the history register holds 0.
  - The history register updates every cycle in every state.
  - A `valid_in` held high therefore never retriggers.
- IDLE + trigger + legal `cs`:
  - Latch all of `d` into an internal buffer.
  - Load base = 0 / 288 / 576 / 864 / 1152 for `LAYER0` / `LAYER1` / `LAYER2` / `LAYER3` / `AFFINE`.
  - Clear the counter and go to WRITE.
- IDLE + trigger + illegal `cs` (any other code): ignore the trigger. No writes, no `done`.
- WRITE, each cycle with counter = i < N_WORDS:
  - Register `we`=1, `waddr`=base+i, `wdata`=buffer word i.
  - Increment i.
- WRITE with counter = N_WORDS:
  - Register `we`=0 and `done`=1, then go to IDLE.
  - `waddr` and `wdata` keep their last values.
- `busy`=1 in WRITE, 0 in IDLE.
- Changes to `d` after capture have no effect on the transfer in progress.
- A trigger that arrives during WRITE is dropped, not queued.
- `cs` changes during WRITE (`cs` differs from the registered previous `cs`):
  - Abort on the next edge: `we`=0, `busy`=0, `done` stays 0, go to IDLE.
  - Words already written stay in the RAM.
- Address arithmetic is unsigned ADDR_W bits and never wraps for legal `cs`.

## Timing
- Trigger sampled at edge T:
  - First write visible after edge T+1: `we`=1, `waddr`=base, `wdata`=word 0.
  - Last write visible after edge T+288: `waddr`=base+287.
  - After edge T+289: `we`=0, `done`=1, `busy`=0.
  - After edge T+290: `done`=0.
- `busy` rises after edge T and stays high through edge T+288.
- A transfer takes 289 cycles from trigger to `done`.
- Back-to-back transfers: a new trigger is accepted at edge T+290 at the earliest, provided `valid_in` has been low for at least one sampled edge in between.
- The RAM writes on the clock edge after `we`/`waddr`/`wdata` are presented; the block needs no RAM read latency.
- `rst_n` low at any time, including mid-transfer: all outputs go to their reset values immediately, without waiting for a clock edge. The transfer is lost.

## Test plan
- Basic transfer:
  - Stimulus: `cs`=`LAYER0`, `d` word i = i, pulse `valid_in`.
  - Required: exactly 288 writes at addresses 0..287 with data 0..287 on consecutive cycles; `done` pulses once at trigger+289.
- Layer base:
  - Stimulus: `cs`=`LAYER2`, `d` word i = 1000+i.
  - Required: first write to address 576 with data 1000; last write to address 863 with data 1287.
  - Repeat with `AFFINE`; required last address is 1439.
- Input stability:
  - Stimulus: change `d` to all-ones one cycle after the trigger.
  - Required: the written data is still the captured values.
  - Stimulus: hold `valid_in` high for 600 cycles.
  - Required: exactly one transfer.
- Abort:
  - Stimulus: switch `cs` from `LAYER1` to `LAYER3` after 100 writes.
  - Required: `we` is low from the next cycle, `done` never pulses, `busy`=0.
  - Stimulus: a fresh `valid_in` rise afterwards.
  - Required: a full transfer at base 864.
- Illegal `cs` and mid-transfer trigger:
  - Stimulus: `cs`=4'hF plus a trigger.
  - Required: no writes, no `done`.
  - Stimulus: a second rise of `valid_in` at write 50 of an active transfer.
  - Required: ignored; exactly 288 writes total.
- Reset mid-transfer:
  - Stimulus: drop `rst_n` at write 200.
  - Required: `we`/`busy`/`done`/`waddr`/`wdata` are 0 without a clock edge.
  - Stimulus: release `rst_n`, then trigger.
  - Required: a clean 288-word transfer.
